// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_pkg : shared defaults and FSM encoding for cache_reader         |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
package cache_pkg;
   localparam int c_def_depth = 70;
   localparam int c_def_width = 32;
   localparam int c_cnt_w     = $clog2(c_def_depth + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;
endpackage
`default_nettype wire

// File: rtl/cache_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem : word store, synchronous write, async read, clear-all      |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
module cache_mem #(
   parameter int DEPTH = 70,
   parameter int WIDTH = 32,
   parameter int AW    = 7
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_clear,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_clear) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
endmodule
`default_nettype wire

// File: rtl/cache_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_reader : write-then-drain buffer with ready/valid readout       |
// | Optional CACHE_READER_SUM_EN adds a running sum of drained words.     |
// | Rev 1.0      : initial release                                       |
// +----------------------------------------------------------------------+
module cache_reader
   import cache_pkg::*;
#(
   parameter int DEPTH = c_def_depth,
   parameter int WIDTH = c_def_width
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic [WIDTH-1:0]           writeData,
   input  logic                       writeCache,
   input  logic                       drain,
   output logic [WIDTH-1:0]           readData,
   output logic                       readValid,
   input  logic                       readReady,
   output logic                       readLast,
   output logic                       drainDone,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       dropped,
   output logic [WIDTH-1:0]           sumOut
);
   localparam int c_cw = $clog2(DEPTH + 1);
   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            r_state;
   logic [c_cw-1:0]   r_count;
   logic [c_cw-1:0]   r_ptr;
   logic              r_done;
   logic              r_dropped;

   logic              w_full;
   logic              w_wr_ok;
   logic              w_wr_drop;
   logic              w_drain_start;
   logic              w_beat;
   logic              w_last;
   logic              w_clear;
   logic [WIDTH-1:0]  w_rdata;

   assign w_full        = (r_count == c_cw'(DEPTH));
   assign w_wr_ok       = (r_state == ST_IDLE) && writeCache && !w_full;
   assign w_wr_drop     = writeCache && !w_wr_ok;
   assign w_drain_start = (r_state == ST_IDLE) && drain;
   assign w_last        = (r_state == ST_DRAIN) && (r_ptr == r_count - c_cw'(1));
   assign w_beat        = (r_state == ST_DRAIN) && readReady;
   assign w_clear       = w_beat && w_last;

   cache_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (c_aw)
   ) u_mem (
      .Clk     (Clk),
      .Rst     (Rst),
      .i_we    (w_wr_ok),
      .i_waddr (r_count[c_aw-1:0]),
      .i_wdata (writeData),
      .i_clear (w_clear),
      .i_raddr (r_ptr[c_aw-1:0]),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_ptr     <= '0;
         r_done    <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_wr_drop) r_dropped <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_wr_ok) r_count <= r_count + c_cw'(1);
               if (drain) begin
                  r_ptr <= '0;
                  // A same-cycle write counts, so the drain is not empty.
                  if ((r_count != '0) || w_wr_ok) r_state <= ST_DRAIN;
                  else                            r_done  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_beat) begin
                  if (w_last) begin
                     r_state <= ST_IDLE;
                     r_count <= '0;
                     r_ptr   <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + c_cw'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign readValid = (r_state == ST_DRAIN);
   assign readData  = readValid ? w_rdata : '0;
   assign readLast  = w_last;
   assign drainDone = r_done;
   assign count     = r_count;
   assign full      = w_full;
   assign dropped   = r_dropped;

`ifdef CACHE_READER_SUM_EN
   logic [WIDTH-1:0] r_sum;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)               r_sum <= '0;
      else if (w_drain_start) r_sum <= '0;
      else if (w_beat)        r_sum <= r_sum + readData;
   end

   assign sumOut = r_sum;
`else
   assign sumOut = '0;
`endif
endmodule
`default_nettype wire

// File: doc/cache_reader.md
CACHE_READER -- requirements
Module: cache_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 70: number of stored words.
REQ-002 SHALL have parameter WIDTH, default 32: data word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, listed first:
- Clk  input  1  clock; all state changes on its rising edge.
- Rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port writeData  input  WIDTH: word to store.
REQ-005 SHALL have port writeCache  input  1: store writeData this cycle.
REQ-006 SHALL have port drain  input  1: start readout of all stored words.
REQ-007 SHALL have port readData  output  WIDTH: current readout word.
REQ-008 SHALL have port readValid  output  1: readData is valid.
REQ-009 SHALL have port readReady  input  1: consumer accepts the word.
REQ-010 SHALL have port readLast  output  1: current word is the final one.
REQ-011 SHALL have port drainDone  output  1: one-cycle pulse when a drain completes.
REQ-012 SHALL have port count  output  clog2(DEPTH+1): number of stored words.
REQ-013 SHALL have port full  output  1: count == DEPTH.
REQ-014 SHALL have port dropped  output  1: sticky flag, a write was discarded.
REQ-015 SHALL have port sumOut  output  WIDTH: sum of the last drained words (see REQ-030).

Function
REQ-016 SHALL implement an FSM with states IDLE and DRAIN; reset state is IDLE.
REQ-017 In IDLE with writeCache=1 and !full, SHALL store writeData at index count and increment count at the edge.
REQ-018 A write with full=1, or any write in DRAIN, SHALL be discarded and SHALL set dropped.
REQ-019 In IDLE, drain=1 SHALL move the FSM to DRAIN at the edge with the read pointer at 0; drain is ignored in DRAIN.
REQ-020 If writeCache and drain are both high in IDLE, the write SHALL be stored first and included in the drain.
REQ-021 In DRAIN, readValid SHALL be 1 and readData SHALL be the entry at the read pointer; first readValid comes 1 cycle after drain is sampled.
REQ-022 A beat SHALL transfer when readValid && readReady; the pointer then advances by 1.
REQ-023 While readValid && !readReady, readData and readLast SHALL hold stable.
REQ-024 readLast SHALL be 1 when the pointer equals count-1.
REQ-025 On the readLast beat, the block SHALL:
- clear count and all entries to 0;
- return to IDLE;
- pulse drainDone for exactly one cycle after that edge.
REQ-026 drain with count==0 SHALL produce no beats and SHALL pulse drainDone in the following cycle.
REQ-027 Outside DRAIN, readValid, readLast and readData SHALL be 0.
REQ-028 dropped SHALL clear only on reset.

Reset
REQ-029 Rst low SHALL immediately set:
- FSM to IDLE;
- count, pointer, all entries, readData, readValid, readLast, drainDone, dropped and sumOut to 0.
This applies mid-drain as well.

Configuration
REQ-030 With CACHE_READER_SUM_EN defined, sumOut SHALL:
- be 0 at drain start;
- accumulate each transferred word modulo 2^WIDTH;
- be final when drainDone pulses;
- hold its value until the next drain.
Without the macro, sumOut SHALL be tied to 0 and no adder SHALL be built.

Structure
REQ-031 Package cache_pkg SHALL hold the DEPTH/WIDTH defaults, the count width constant and the FSM state encoding.
REQ-032 Storage SHALL be sub-module cache_mem, with synchronous write, asynchronous read and clear-all input; control stays in cache_reader.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Write 3, 5, 7, then drain with readReady=1: beats 3, 5, 7; readLast on 7; drainDone 1 cycle later; count=0; sumOut=15 (SUM_EN).
- 70 writes, then a 71st: full=1, dropped=1, count=70; drain yields 70 beats in order.
- Drain with readReady toggling 1010...: each word held stable while stalled; no word lost or duplicated.
- writeCache (value 9) and drain in the same IDLE cycle with count=0: single beat 9 with readLast=1.
- Drain on an empty buffer: readValid never rises; drainDone pulses once.
- Rst low after 2 of 5 beats: all outputs 0, IDLE, count=0; a subsequent drain yields no beats.
